mem_responder: RTL
==================

Name: mem_responder

Overview:
Memory-side responder for the CPU's 16-bit memory port. It serves instruction fetches, loads and stores issued by the core.
- Decodes each byte address into an internal word RAM or a small MMIO register file.
- Returns read data after a fixed, parameterised latency, with a valid strobe.
- Sits between the cpu and top-level board I/O (LEDs, switches).

Parameters:
RAM_WORDS, 4096, number of 16-bit words in internal RAM; power of two, at most 16384.
READ_LATENCY, 1, cycles from read request to o_mem_rddatavalid; legal range 1..4.
MMIO_BASE, 16'hF000, byte base address of the MMIO window; 16-byte aligned.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
i_mem_addr  in  16  byte address from the cpu; bit 0 ignored (word access only)
i_mem_rd  in  1  read request, sampled each cycle
i_mem_wr  in  1  write request, sampled each cycle
i_mem_wrdata  in  16  write data
o_mem_rddata  out  16  read data
o_mem_rddatavalid  out  1  one-cycle strobe marking valid o_mem_rddata
i_switches  in  8  asynchronous board switches
o_leds  out  8  LED register output

Behaviour:
- Single clock domain: clk.
- Reset is synchronous and active-high on reset. While reset is high, all of the following hold:
  - o_mem_rddata = 0, o_mem_rddatavalid = 0.
  - Read pipeline emptied; in-flight reads are dropped and produce no valid strobe.
  - o_leds = 0, cycle counter = 0, switch synchronisers = 0.
  - RAM contents are not cleared.
- Address decode uses word index = i_mem_addr[15:1]:
  - RAM: i_mem_addr < 2*RAM_WORDS.
  - MMIO_BASE+0: LED register (RW; bits [7:0] used, upper bits read as 0).
  - MMIO_BASE+2: switch register (RO). Value is i_switches passed through a 2-flop synchroniser, zero-extended.
  - MMIO_BASE+4: cycle counter (RW). 16-bit, free-running, +1 every cycle, wraps 16'hFFFF -> 0. A write loads i_mem_wrdata; counting resumes from that value the next cycle.
  - MMIO_BASE+6..+14: reserved; read 0, writes ignored.
  - Any other address is unmapped: read 0, write ignored.
- Writes:
  - Committed at the clock edge where i_mem_wr = 1.
  - No response strobe.
- Reads:
  - Data is captured at the request edge. It emerges on o_mem_rddata with o_mem_rddatavalid = 1 exactly READ_LATENCY cycles later.
  - Fully pipelined: a new read is accepted every cycle, and responses come back in request order.
- Simultaneous i_mem_rd and i_mem_wr to the same address:
  - The read returns the pre-write (old) data.
  - The write still commits.
  - Switch and counter reads return the value sampled at the request edge.
- o_mem_rddata holds its last value while o_mem_rddatavalid = 0; it is not zeroed.
- Implementation: pipeline shift register of READ_LATENCY stages, each stage carrying {valid, data}.
- No stalls and no backpressure: the cpu may issue one request per cycle indefinitely.

Optional Feature:
Macro MEM_ACCESS_CHECK_EN.
- Defined:
  - Adds output o_mem_err (1 bit).
  - o_mem_err is sticky: it sets on any unmapped or reserved access, on any write to MMIO_BASE+2, and on any request with i_mem_addr[0] = 1.
  - It clears only on reset.
  - It goes high one cycle after the offending request.
- Not defined:
  - No o_mem_err port exists.
  - These accesses are silently handled per the decode rules above.

Test Plan:
- Reset: hold reset 3 cycles with i_mem_rd = 1 -> o_mem_rddatavalid = 0, o_leds = 0 throughout; counter reads 0x0000 or 0x0001 on the first read after release.
- RAM write then read: wr 0x1234 to 0x0010; rd 0x0010 next cycle with READ_LATENCY = 1 -> 0x1234 with valid exactly 1 cycle after the rd. Repeat with READ_LATENCY = 3 -> valid 3 cycles after.
- Back-to-back reads of 0x0000, 0x0002, 0x0004 (preloaded 0xAAAA, 0xBBBB, 0xCCCC) -> three consecutive valid strobes, in order.
- Same-cycle rd+wr: 0x0020 holds 0x1111; rd+wr 0x2222 in one cycle -> returns 0x1111; a subsequent read returns 0x2222.
- MMIO:
  - wr 0x00A5 to MMIO_BASE -> o_leds = 0xA5 next cycle.
  - i_switches = 0x3C -> read MMIO_BASE+2 at least 3 cycles later returns 0x003C.
  - wr 0xFFFE to MMIO_BASE+4 -> counter reads later show the wrap to 0x0000.
- Unmapped: rd 0xE000 with RAM_WORDS = 4096 -> 0x0000 with valid. With MEM_ACCESS_CHECK_EN, o_mem_err rises 1 cycle after the request and stays high until reset.

Source files
------------

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Word RAM + MMIO (LEDs, switches, cycle counter) responder for the
//            16-bit CPU memory port with a fixed-latency read pipeline.
//            Optional macro MEM_ACCESS_CHECK_EN adds sticky o_mem_err.
// Revision : 1.0
// ============================================================================
module mem_responder #(
    parameter int          RAM_WORDS    = 4096,
    parameter int          READ_LATENCY = 1,
    parameter logic [15:0] MMIO_BASE    = 16'hF000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] i_mem_addr,
    input  logic        i_mem_rd,
    input  logic        i_mem_wr,
    input  logic [15:0] i_mem_wrdata,
    output logic [15:0] o_mem_rddata,
    output logic        o_mem_rddatavalid,
    input  logic [7:0]  i_switches,
    output logic [7:0]  o_leds
`ifdef MEM_ACCESS_CHECK_EN
    ,
    output logic        o_mem_err
`endif
);

    localparam int          c_RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [16:0] c_RAM_BYTES = 17'(2 * RAM_WORDS);
    localparam logic [11:0] c_MMIO_PAGE = MMIO_BASE[15:4];
    localparam logic [2:0]  c_REG_LEDS  = 3'd0;
    localparam logic [2:0]  c_REG_SW    = 3'd1;
    localparam logic [2:0]  c_REG_CNT   = 3'd2;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                w_is_ram;
    logic                w_is_mmio;
    logic [2:0]          w_reg_sel;
    logic [c_RAM_AW-1:0] w_ram_idx;

    assign w_is_ram  = ({1'b0, i_mem_addr} < c_RAM_BYTES);
    assign w_is_mmio = !w_is_ram && (i_mem_addr[15:4] == c_MMIO_PAGE);
    assign w_reg_sel = i_mem_addr[3:1];
    assign w_ram_idx = i_mem_addr[c_RAM_AW:1];

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic [15:0] r_ram [RAM_WORDS];
    logic [7:0]  r_leds;
    logic [7:0]  r_sw_meta;
    logic [7:0]  r_sw_sync;
    logic [15:0] r_cycle_cnt;

    logic w_wr_leds;
    logic w_wr_cnt;

    assign w_wr_leds = i_mem_wr && w_is_mmio && (w_reg_sel == c_REG_LEDS);
    assign w_wr_cnt  = i_mem_wr && w_is_mmio && (w_reg_sel == c_REG_CNT);

    // RAM has no reset so its contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (i_mem_wr && w_is_ram) begin
            r_ram[w_ram_idx] <= i_mem_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds      <= 8'h00;
            r_sw_meta   <= 8'h00;
            r_sw_sync   <= 8'h00;
            r_cycle_cnt <= 16'h0000;
        end else begin
            r_sw_meta <= i_switches;
            r_sw_sync <= r_sw_meta;
            if (w_wr_leds) begin
                r_leds <= i_mem_wrdata[7:0];
            end
            if (w_wr_cnt) begin
                r_cycle_cnt <= i_mem_wrdata;
            end else begin
                r_cycle_cnt <= r_cycle_cnt + 16'd1;
            end
        end
    end

    assign o_leds = r_leds;

    // ------------------------------------------------------------------
    // Read data selection (pre-write values, sampled at the request edge)
    // ------------------------------------------------------------------
    logic [15:0] w_rd_data;

    always_comb begin
        w_rd_data = 16'h0000;
        if (w_is_ram) begin
            w_rd_data = r_ram[w_ram_idx];
        end else if (w_is_mmio) begin
            case (w_reg_sel)
                c_REG_LEDS: w_rd_data = {8'h00, r_leds};
                c_REG_SW:   w_rd_data = {8'h00, r_sw_sync};
                c_REG_CNT:  w_rd_data = r_cycle_cnt;
                default:    w_rd_data = 16'h0000;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Read pipeline: stage data only moves with a valid token, so the
    // output holds the last returned word between strobes.
    // ------------------------------------------------------------------
    logic [READ_LATENCY-1:0]       r_pipe_vld;
    logic [READ_LATENCY-1:0][15:0] r_pipe_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe_vld  <= '0;
            r_pipe_data <= '0;
        end else begin
            r_pipe_vld[0] <= i_mem_rd;
            if (i_mem_rd) begin
                r_pipe_data[0] <= w_rd_data;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                if (r_pipe_vld[i-1]) begin
                    r_pipe_data[i] <= r_pipe_data[i-1];
                end
            end
        end
    end

    assign o_mem_rddata      = r_pipe_data[READ_LATENCY-1];
    assign o_mem_rddatavalid = r_pipe_vld[READ_LATENCY-1];

`ifdef MEM_ACCESS_CHECK_EN
    // ------------------------------------------------------------------
    // Sticky access-error flag
    // ------------------------------------------------------------------
    logic w_bad_access;
    logic r_mem_err;

    assign w_bad_access = (i_mem_rd || i_mem_wr) &&
                          (i_mem_addr[0] ||
                           (!w_is_ram && !w_is_mmio) ||
                           (w_is_mmio && (w_reg_sel > c_REG_CNT)) ||
                           (i_mem_wr && w_is_mmio && (w_reg_sel == c_REG_SW)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_err <= 1'b0;
        end else if (w_bad_access) begin
            r_mem_err <= 1'b1;
        end
    end

    assign o_mem_err = r_mem_err;
`else
    // Byte-select bit is meaningless for word-only accesses
    logic w_unused;
    assign w_unused = i_mem_addr[0];
`endif

endmodule
`default_nettype wire
